// File: rtl/cache_scan_seq_if.sv
// rtl/cache_scan_seq_if.sv - command and scan-port bundle for cache_scan_seq
interface cache_scan_seq_if;
  logic         cmd_vld_i;
  logic         cmd_rdy_o;
  logic         cmd_op_i;
  logic [31:0]  cmd_addr_i;
  logic [127:0] cmd_data_i;
  logic [3:0]   cmd_web_i;
  logic         scan_enb_o;
  logic [8:0]   scan_addr_o;
  logic [31:0]  scan_data_o;
  logic [3:0]   scan_web_tag_o;
  logic [3:0]   scan_web_cache_o;
  logic         scan_web_meta_o;
  logic         busy_o;
  logic         done_o;

  modport master (
    output cmd_vld_i, cmd_op_i, cmd_addr_i, cmd_data_i, cmd_web_i,
    input  cmd_rdy_o, scan_enb_o, scan_addr_o, scan_data_o, scan_web_tag_o,
           scan_web_cache_o, scan_web_meta_o, busy_o, done_o
  );

  modport slave (
    input  cmd_vld_i, cmd_op_i, cmd_addr_i, cmd_data_i, cmd_web_i,
    output cmd_rdy_o, scan_enb_o, scan_addr_o, scan_data_o, scan_web_tag_o,
           scan_web_cache_o, scan_web_meta_o, busy_o, done_o
  );
endinterface

// File: rtl/cache_scan_seq.sv
// rtl/cache_scan_seq.sv - turns fill/invalidate commands into cache scan-port write sequences
// Optional grant handshake before each sequence: CACHE_SCAN_SEQ_LOCK_EN.
module cache_scan_seq #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic reset_n,
`ifdef CACHE_SCAN_SEQ_LOCK_EN
  output logic lock_req_o,
  input  logic lock_gnt_i,
`endif
  cache_scan_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DATA     = 3'd1;
  localparam logic [2:0] S_META     = 3'd2;
  localparam logic [2:0] S_TAG      = 3'd3;
  localparam logic [2:0] S_INV      = 3'd4;
  localparam logic [2:0] S_HOLD     = 3'd5;
`ifdef CACHE_SCAN_SEQ_LOCK_EN
  localparam logic [2:0] S_WAIT_GNT = 3'd6;
`endif

  logic [2:0]   state, nxt_state;
  logic [1:0]   beat, nxt_beat;
  logic [3:0]   hold_cnt, nxt_hold;
  logic         accept;

  logic         op_q;
  logic [6:0]   idx_q;
  logic [22:0]  tag_q;
  logic [127:0] data_q;
  logic [3:0]   web_q;

  logic         op_e;
  logic [6:0]   idx_e;
  logic [22:0]  tag_e;
  logic [127:0] data_e;
  logic [3:0]   web_e;

  logic         n_enb, n_wm;
  logic [8:0]   n_addr;
  logic [31:0]  n_data;
  logic [3:0]   n_wt, n_wc;
  logic         unused_addr_lsb;

  assign accept        = bus.cmd_vld_i && (state == S_IDLE);
  assign bus.cmd_rdy_o = (state == S_IDLE);
  assign bus.busy_o    = (state != S_IDLE);
  assign unused_addr_lsb = ^bus.cmd_addr_i[1:0];

  // The first beat is computed from the live inputs in the accept cycle.
  assign op_e   = (state == S_IDLE) ? bus.cmd_op_i         : op_q;
  assign idx_e  = (state == S_IDLE) ? bus.cmd_addr_i[8:2]  : idx_q;
  assign tag_e  = (state == S_IDLE) ? bus.cmd_addr_i[31:9] : tag_q;
  assign data_e = (state == S_IDLE) ? bus.cmd_data_i       : data_q;
  assign web_e  = (state == S_IDLE) ? bus.cmd_web_i        : web_q;

  always_comb begin
    nxt_state = state;
    nxt_beat  = beat;
    nxt_hold  = hold_cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          nxt_beat = 2'd0;
`ifdef CACHE_SCAN_SEQ_LOCK_EN
          nxt_state = S_WAIT_GNT;
`else
          nxt_state = op_e ? S_DATA : S_INV;
`endif
        end
      end
`ifdef CACHE_SCAN_SEQ_LOCK_EN
      S_WAIT_GNT: if (lock_gnt_i) nxt_state = op_e ? S_DATA : S_INV;
`endif
      S_DATA: begin
        if (beat == 2'd3) nxt_state = S_META;
        else              nxt_beat  = beat + 2'd1;
      end
      S_META: nxt_state = S_TAG;
      S_TAG, S_INV: begin
        nxt_state = S_HOLD;
        nxt_hold  = 4'(HOLD_CYCLES - 1);
      end
      S_HOLD: begin
        if (hold_cnt == 4'd0) nxt_state = S_IDLE;
        else                  nxt_hold  = hold_cnt - 4'd1;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Scan values for the state being entered; address/data hold when idle.
  always_comb begin
    n_enb  = 1'b1;
    n_addr = bus.scan_addr_o;
    n_data = bus.scan_data_o;
    n_wt   = 4'hF;
    n_wc   = 4'hF;
    n_wm   = 1'b1;
    case (nxt_state)
      S_DATA: begin
        n_enb  = 1'b0;
        n_addr = {idx_e, nxt_beat};
        n_data = data_e[{nxt_beat, 5'd0} +: 32];
        n_wc   = web_e;
      end
      S_META: begin
        n_enb  = 1'b0;
        n_addr = {2'b00, idx_e};
        n_data = 32'd0;
        n_wm   = 1'b0;
      end
      S_TAG: begin
        n_enb  = 1'b0;
        n_addr = {2'b00, idx_e};
        n_data = {1'b1, 8'd0, tag_e};
        n_wt   = web_e;
      end
      S_INV: begin
        n_enb  = 1'b0;
        n_addr = {2'b00, idx_e};
        n_data = 32'd0;
        n_wt   = 4'h0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= bus.cmd_op_i;
      idx_q  <= bus.cmd_addr_i[8:2];
      tag_q  <= bus.cmd_addr_i[31:9];
      data_q <= bus.cmd_data_i;
      web_q  <= bus.cmd_web_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= S_IDLE;
      beat                 <= 2'd0;
      hold_cnt             <= 4'd0;
      bus.scan_enb_o       <= 1'b1;
      bus.scan_addr_o      <= 9'd0;
      bus.scan_data_o      <= 32'd0;
      bus.scan_web_tag_o   <= 4'hF;
      bus.scan_web_cache_o <= 4'hF;
      bus.scan_web_meta_o  <= 1'b1;
      bus.done_o           <= 1'b0;
`ifdef CACHE_SCAN_SEQ_LOCK_EN
      lock_req_o           <= 1'b0;
`endif
    end else begin
      state                <= nxt_state;
      beat                 <= nxt_beat;
      hold_cnt             <= nxt_hold;
      bus.scan_enb_o       <= n_enb;
      bus.scan_addr_o      <= n_addr;
      bus.scan_data_o      <= n_data;
      bus.scan_web_tag_o   <= n_wt;
      bus.scan_web_cache_o <= n_wc;
      bus.scan_web_meta_o  <= n_wm;
      bus.done_o           <= (state == S_HOLD) && (hold_cnt == 4'd0);
`ifdef CACHE_SCAN_SEQ_LOCK_EN
      lock_req_o           <= (nxt_state != S_IDLE);
`endif
    end
  end

endmodule

// File: tb/tb_cache_scan_seq.sv
// tb/tb_cache_scan_seq.sv - directed self-checking bench for cache_scan_seq (HOLD_CYCLES=2)
// Exercises the grant handshake too when CACHE_SCAN_SEQ_LOCK_EN is defined.
module tb_cache_scan_seq;
  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  cache_scan_seq_if bus ();

`ifdef CACHE_SCAN_SEQ_LOCK_EN
  logic lock_req;
  logic lock_gnt;
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  cache_scan_seq #(.HOLD_CYCLES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
`ifdef CACHE_SCAN_SEQ_LOCK_EN
    .lock_req_o (lock_req),
    .lock_gnt_i (lock_gnt),
`endif
    .bus        (bus)
  );

  localparam logic [127:0] D_FILL = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] D_B2B  = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
  localparam logic [127:0] D_MASK = 128'h0000_0004_0000_0003_0000_0002_0000_0001;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_scan(input string tag, input logic enb, input logic [8:0] addr,
                          input logic [31:0] data, input logic [3:0] wt,
                          input logic [3:0] wc, input logic wm);
    chk({tag, ".enb"},  bus.scan_enb_o,       enb);
    chk({tag, ".addr"}, bus.scan_addr_o,      addr);
    chk({tag, ".data"}, bus.scan_data_o,      data);
    chk({tag, ".wt"},   bus.scan_web_tag_o,   wt);
    chk({tag, ".wc"},   bus.scan_web_cache_o, wc);
    chk({tag, ".wm"},   bus.scan_web_meta_o,  wm);
  endtask

  task automatic start(input logic op, input logic [31:0] addr,
                       input logic [127:0] data, input logic [3:0] web);
    bus.cmd_vld_i  = 1'b1;
    bus.cmd_op_i   = op;
    bus.cmd_addr_i = addr;
    bus.cmd_data_i = data;
    bus.cmd_web_i  = web;
  endtask

  // Ends at the first beat cycle (T+1, plus the grant cycle when locking).
  task automatic accepted();
    @(negedge clk);
    bus.cmd_vld_i = 1'b0;
    cyc(LAT);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n        = 1'b0;
    bus.cmd_vld_i  = 1'b0;
    bus.cmd_op_i   = 1'b0;
    bus.cmd_addr_i = 32'd0;
    bus.cmd_data_i = 128'd0;
    bus.cmd_web_i  = 4'hF;
`ifdef CACHE_SCAN_SEQ_LOCK_EN
    lock_gnt = 1'b1;
`endif
    cyc(2);
    chk_scan("rst", 1'b1, 9'h000, 32'h0, 4'hF, 4'hF, 1'b1);
    chk("rst.busy", bus.busy_o, 1'b0);
    chk("rst.done", bus.done_o, 1'b0);
    chk("rst.rdy",  bus.cmd_rdy_o, 1'b1);
`ifdef CACHE_SCAN_SEQ_LOCK_EN
    chk("rst.lock_req", lock_req, 1'b0);
`endif
    reset_n = 1'b1;
    cyc(1);

    // Fill 0x1234: idx 0x0D, tag word 0x80000009
    start(1'b1, 32'h0000_1234, D_FILL, 4'h0);
    chk("fill.rdy_T", bus.cmd_rdy_o, 1'b1);
    accepted();
    chk_scan("fill.b0", 1'b0, 9'h034, 32'h1111_1111, 4'hF, 4'h0, 1'b1);
    chk("fill.busy", bus.busy_o, 1'b1);
    chk("fill.rdy_busy", bus.cmd_rdy_o, 1'b0);
    cyc(1); chk_scan("fill.b1", 1'b0, 9'h035, 32'h2222_2222, 4'hF, 4'h0, 1'b1);
    cyc(1); chk_scan("fill.b2", 1'b0, 9'h036, 32'h3333_3333, 4'hF, 4'h0, 1'b1);
    cyc(1); chk_scan("fill.b3", 1'b0, 9'h037, 32'h4444_4444, 4'hF, 4'h0, 1'b1);
    cyc(1); chk_scan("fill.meta", 1'b0, 9'h00D, 32'h0, 4'hF, 4'hF, 1'b0);
    cyc(1); chk_scan("fill.tag", 1'b0, 9'h00D, 32'h8000_0009, 4'h0, 4'hF, 1'b1);
    cyc(1); chk_scan("fill.hold0", 1'b1, 9'h00D, 32'h8000_0009, 4'hF, 4'hF, 1'b1);
    chk("fill.hold0.done", bus.done_o, 1'b0);
    cyc(1); chk("fill.hold1.enb", bus.scan_enb_o, 1'b1);
    chk("fill.hold1.done", bus.done_o, 1'b0);
    chk("fill.hold1.busy", bus.busy_o, 1'b1);
    cyc(1); chk("fill.done", bus.done_o, 1'b1);
    chk("fill.done.rdy",  bus.cmd_rdy_o, 1'b1);
    chk("fill.done.busy", bus.busy_o, 1'b0);
    cyc(1); chk("fill.done_pulse", bus.done_o, 1'b0);

    // Invalidate 0x1FC with an all-ones mask: tag lanes still cleared
    start(1'b0, 32'h0000_01FC, 128'd0, 4'hF);
    accepted();
    chk_scan("inv.beat", 1'b0, 9'h07F, 32'h0, 4'h0, 4'hF, 1'b1);
    cyc(1); chk("inv.hold0.enb", bus.scan_enb_o, 1'b1);
    chk("inv.hold0.done", bus.done_o, 1'b0);
    cyc(1); chk("inv.hold1.done", bus.done_o, 1'b0);
    cyc(1); chk("inv.done", bus.done_o, 1'b1);
    chk("inv.done.rdy", bus.cmd_rdy_o, 1'b1);
    cyc(1);

    // Back-to-back: fill 0xA88 (idx 0x22, tag 0x80000005), invalidate 0x4 held valid
    start(1'b1, 32'h0000_0A88, D_B2B, 4'h0);
    @(negedge clk);
    start(1'b0, 32'h0000_0004, 128'd0, 4'hF);
    cyc(LAT);
    chk_scan("b2b.b0", 1'b0, 9'h088, 32'hAAAA_AAAA, 4'hF, 4'h0, 1'b1);
    chk("b2b.rdy_busy", bus.cmd_rdy_o, 1'b0);
    cyc(1); chk_scan("b2b.b1", 1'b0, 9'h089, 32'hBBBB_BBBB, 4'hF, 4'h0, 1'b1);
    cyc(4); chk_scan("b2b.tag", 1'b0, 9'h022, 32'h8000_0005, 4'h0, 4'hF, 1'b1);
    cyc(3); chk("b2b.done", bus.done_o, 1'b1);
    chk("b2b.done.rdy", bus.cmd_rdy_o, 1'b1);
    @(negedge clk);
    bus.cmd_vld_i = 1'b0;
    cyc(LAT);
    chk_scan("b2b.inv", 1'b0, 9'h001, 32'h0, 4'h0, 4'hF, 1'b1);
    cyc(3); chk("b2b.inv_done", bus.done_o, 1'b1);
    cyc(1);

    // Mask 1010 applies to data and tag beats only
    start(1'b1, 32'h0000_0010, D_MASK, 4'hA);
    accepted();
    chk_scan("mask.b0", 1'b0, 9'h010, 32'h1, 4'hF, 4'hA, 1'b1);
    cyc(3); chk_scan("mask.b3", 1'b0, 9'h013, 32'h4, 4'hF, 4'hA, 1'b1);
    cyc(1); chk_scan("mask.meta", 1'b0, 9'h004, 32'h0, 4'hF, 4'hF, 1'b0);
    cyc(1); chk_scan("mask.tag", 1'b0, 9'h004, 32'h8000_0000, 4'hA, 4'hF, 1'b1);
    cyc(3); chk("mask.done", bus.done_o, 1'b1);
    cyc(1);

    // Reset during data beat 2 aborts silently
    start(1'b1, 32'h0000_1234, D_FILL, 4'h0);
    accepted();
    cyc(2); chk_scan("rmid.b2", 1'b0, 9'h036, 32'h3333_3333, 4'hF, 4'h0, 1'b1);
    #1 reset_n = 1'b0;
    #1 chk_scan("rmid.async", 1'b1, 9'h000, 32'h0, 4'hF, 4'hF, 1'b1);
    chk("rmid.busy", bus.busy_o, 1'b0);
    cyc(2);
    reset_n = 1'b1;
    chk("rmid.rdy", bus.cmd_rdy_o, 1'b1);
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk("rmid.no_done", bus.done_o, 1'b0);
    end

`ifdef CACHE_SCAN_SEQ_LOCK_EN
    // Grant withheld for five cycles after accept
    lock_gnt = 1'b0;
    start(1'b1, 32'h0000_1234, D_FILL, 4'h0);
    chk("lock.req_T", lock_req, 1'b0);
    @(negedge clk);
    bus.cmd_vld_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk("lock.wait.enb", bus.scan_enb_o, 1'b1);
      chk("lock.wait.req", lock_req, 1'b1);
      if (k < 5) cyc(1);
    end
    lock_gnt = 1'b1;
    cyc(1); chk_scan("lock.b0", 1'b0, 9'h034, 32'h1111_1111, 4'hF, 4'h0, 1'b1);
    chk("lock.b0.req", lock_req, 1'b1);
    cyc(7); chk("lock.hold.req", lock_req, 1'b1);
    chk("lock.hold.enb", bus.scan_enb_o, 1'b1);
    cyc(1); chk("lock.done", bus.done_o, 1'b1);
    chk("lock.done.req", lock_req, 1'b0);
    cyc(1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
